// File: rtl/agu_req_arbiter.sv
// Shares one address-generation unit among NUM_REQ requesters: grants one request at a time
// and holds the AGU inputs until the burst finishes. Define AGU_ARB_FIXED_PRIO_EN for fixed priority.
module agu_req_arbiter #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned OFF_WIDTH  = 8,
    localparam int unsigned IdW       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*3-1:0]          req_max_reg,
    input  logic [NUM_REQ*OFF_WIDTH-1:0]  req_max_off,
    input  logic [NUM_REQ*3-1:0]          req_sew,
    output logic                          agu_en,
    output logic [ADDR_WIDTH-1:0]         agu_addr,
    output logic [2:0]                    agu_max_reg,
    output logic [OFF_WIDTH-1:0]          agu_max_off,
    output logic [2:0]                    agu_sew,
    input  logic                          agu_idle,
    output logic                          busy,
    output logic [IdW-1:0]                gnt_id,
    output logic                          done_valid,
    output logic [IdW-1:0]                done_id
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StBusy
    } state_e;

    state_e                state_q, state_d;
    logic [IdW-1:0]        gnt_id_q, gnt_id_d;
    logic [ADDR_WIDTH-1:0] agu_addr_q, agu_addr_d;
    logic [2:0]            agu_max_reg_q, agu_max_reg_d;
    logic [OFF_WIDTH-1:0]  agu_max_off_q, agu_max_off_d;
    logic [2:0]            agu_sew_q, agu_sew_d;
    logic [IdW-1:0]        winner;

    logic [ADDR_WIDTH-1:0] addr_arr    [NUM_REQ];
    logic [2:0]            max_reg_arr [NUM_REQ];
    logic [OFF_WIDTH-1:0]  max_off_arr [NUM_REQ];
    logic [2:0]            sew_arr     [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i]    = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            max_reg_arr[i] = req_max_reg[i*3 +: 3];
            max_off_arr[i] = req_max_off[i*OFF_WIDTH +: OFF_WIDTH];
            sew_arr[i]     = req_sew[i*3 +: 3];
        end
    end

`ifdef AGU_ARB_FIXED_PRIO_EN
    // Scan downward so the lowest valid index is the last one written.
    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                winner = IdW'(i);
            end
        end
    end
`else
    logic [IdW-1:0] last_gnt_q, last_gnt_d;
    logic [IdW-1:0] cand;
    int unsigned    cand_int;
    logic           found;

    // Search upward from the slot after the last grant, wrapping at NUM_REQ.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        cand     = '0;
        cand_int = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand_int = 32'(last_gnt_q) + i;
            if (cand_int >= NUM_REQ) begin
                cand_int = cand_int - NUM_REQ;
            end
            cand = IdW'(cand_int);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (state_q == StIssue) begin
            last_gnt_d = gnt_id_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= IdW'(NUM_REQ - 1);
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`endif

    always_comb begin
        state_d       = state_q;
        gnt_id_d      = gnt_id_q;
        agu_addr_d    = agu_addr_q;
        agu_max_reg_d = agu_max_reg_q;
        agu_max_off_d = agu_max_off_q;
        agu_sew_d     = agu_sew_q;
        agu_en        = 1'b0;
        req_ready     = '0;
        done_valid    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|req_valid) begin
                    state_d       = StIssue;
                    gnt_id_d      = winner;
                    agu_addr_d    = addr_arr[winner];
                    agu_max_reg_d = max_reg_arr[winner];
                    agu_max_off_d = max_off_arr[winner];
                    agu_sew_d     = sew_arr[winner];
                end
            end
            StIssue: begin
                agu_en              = 1'b1;
                req_ready[gnt_id_q] = 1'b1;
                state_d             = StBusy;
            end
            StBusy: begin
                if (agu_idle) begin
                    done_valid = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            gnt_id_q      <= '0;
            agu_addr_q    <= '0;
            agu_max_reg_q <= '0;
            agu_max_off_q <= '0;
            agu_sew_q     <= '0;
        end else begin
            state_q       <= state_d;
            gnt_id_q      <= gnt_id_d;
            agu_addr_q    <= agu_addr_d;
            agu_max_reg_q <= agu_max_reg_d;
            agu_max_off_q <= agu_max_off_d;
            agu_sew_q     <= agu_sew_d;
        end
    end

    assign agu_addr    = agu_addr_q;
    assign agu_max_reg = agu_max_reg_q;
    assign agu_max_off = agu_max_off_q;
    assign agu_sew     = agu_sew_q;
    assign gnt_id      = gnt_id_q;
    assign done_id     = gnt_id_q;
    assign busy        = (state_q != StIdle);

endmodule
